// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, control-word layout and aluOp encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;
    localparam int c_XLEN    = 16;
    localparam int c_REG_AW  = 4;
    localparam int c_NUM_REG = 16;

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_ADD   = 4'h1;
    localparam logic [3:0] c_OP_SUB   = 4'h2;
    localparam logic [3:0] c_OP_AND   = 4'h3;
    localparam logic [3:0] c_OP_OR    = 4'h4;
    localparam logic [3:0] c_OP_XOR   = 4'h5;
    localparam logic [3:0] c_OP_SLL   = 4'h6;
    localparam logic [3:0] c_OP_SRL   = 4'h7;
    localparam logic [3:0] c_OP_LOAD  = 4'h8;
    localparam logic [3:0] c_OP_STORE = 4'h9;
    localparam logic [3:0] c_OP_VADD  = 4'hA;

    localparam int c_BIT_VWRE   = 9;
    localparam int c_BIT_LOAD   = 8;
    localparam int c_BIT_WRE    = 7;
    localparam int c_BIT_MEMWE  = 6;
    localparam int c_WBSEL_LSB  = 4;
    localparam int c_ALUOP_LSB  = 0;

    localparam logic [1:0] c_WB_ALU  = 2'b00;
    localparam logic [1:0] c_WB_MEM  = 2'b01;
    localparam logic [1:0] c_WB_VEC  = 2'b10;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b0110;
    localparam logic [3:0] c_ALU_VADD = 4'b0111;

    // Only defined opcodes read registers, so only they can suffer a load-use hazard.
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op != c_OP_NOP) && (op <= c_OP_VADD);
    endfunction

    function automatic logic [15:0] decode_ctrl(input logic [3:0] op);
        logic [15:0] ctrl;
        ctrl = '0;
        case (op)
            c_OP_ADD:   begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_ADD; end
            c_OP_SUB:   begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_SUB; end
            c_OP_AND:   begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_AND; end
            c_OP_OR:    begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_OR;  end
            c_OP_XOR:   begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_XOR; end
            c_OP_SLL:   begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_SLL; end
            c_OP_SRL:   begin ctrl[c_BIT_WRE] = 1'b1; ctrl[c_ALUOP_LSB +: 4] = c_ALU_SRL; end
            c_OP_LOAD: begin
                ctrl[c_BIT_WRE]          = 1'b1;
                ctrl[c_BIT_LOAD]         = 1'b1;
                ctrl[c_WBSEL_LSB +: 2]   = c_WB_MEM;
                ctrl[c_ALUOP_LSB +: 4]   = c_ALU_ADD;
            end
            c_OP_STORE: begin
                ctrl[c_BIT_MEMWE]        = 1'b1;
                ctrl[c_ALUOP_LSB +: 4]   = c_ALU_ADD;
            end
            c_OP_VADD: begin
                ctrl[c_BIT_VWRE]         = 1'b1;
                ctrl[c_WBSEL_LSB +: 2]   = c_WB_VEC;
                ctrl[c_ALUOP_LSB +: 4]   = c_ALU_VADD;
            end
            default:    ctrl = '0;
        endcase
        return ctrl;
    endfunction
endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Pipeline-side signal bundle of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    import cpu_pkg::*;

    logic [c_XLEN-1:0]   instr_fetch;
    logic                flush;
    logic                load_execute;
    logic [c_REG_AW-1:0] rd_execute;
    logic                wb_we;
    logic [c_REG_AW-1:0] wb_rd;
    logic [c_XLEN-1:0]   wb_data;
    logic [c_XLEN-1:0]   nop_mux_output;
    logic [c_XLEN-1:0]   srcA;
    logic [c_XLEN-1:0]   srcB;
    logic [c_REG_AW-1:0] rs1_decode;
    logic [c_REG_AW-1:0] rs2_decode;
    logic [c_REG_AW-1:0] rd_decode;
    logic                stall_fetch;

    modport master (
        output instr_fetch, flush, load_execute, rd_execute, wb_we, wb_rd, wb_data,
        input  nop_mux_output, srcA, srcB, rs1_decode, rs2_decode, rd_decode, stall_fetch
    );

    modport slave (
        input  instr_fetch, flush, load_execute, rd_execute, wb_we, wb_rd, wb_data,
        output nop_mux_output, srcA, srcB, rs1_decode, rs2_decode, rd_decode, stall_fetch
    );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 16x16 register file, 2 read / 1 write, R0 = 0, write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import cpu_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic [c_REG_AW-1:0] i_rs1_addr,
    input  wire logic [c_REG_AW-1:0] i_rs2_addr,
    output logic      [c_XLEN-1:0]   o_rs1_data,
    output logic      [c_XLEN-1:0]   o_rs2_data,
    input  wire logic                i_we,
    input  wire logic [c_REG_AW-1:0] i_wr_addr,
    input  wire logic [c_XLEN-1:0]   i_wr_data
);
    logic [c_XLEN-1:0] r_regs [c_NUM_REG];
    logic              w_wr_en;

    assign w_wr_en = i_we && (i_wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Same-cycle writeback wins over the stored value so decode sees fresh data.
    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        if (i_rs1_addr != '0) begin
            o_rs1_data = (w_wr_en && (i_wr_addr == i_rs1_addr)) ? i_wr_data : r_regs[i_rs1_addr];
        end
        if (i_rs2_addr != '0) begin
            o_rs2_data = (w_wr_en && (i_wr_addr == i_rs2_addr)) ? i_wr_data : r_regs[i_rs2_addr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : IF/ID register, opcode decode, register read, load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import cpu_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    decode_stage_if.slave  bus
);
    logic [c_XLEN-1:0]   r_instr_id;
    logic [3:0]          w_opcode;
    logic [c_REG_AW-1:0] w_rd;
    logic [c_REG_AW-1:0] w_rs1;
    logic [c_REG_AW-1:0] w_rs2;
    logic                w_stall;
    logic [c_XLEN-1:0]   w_ctrl;

    assign w_opcode = r_instr_id[15:12];
    assign w_rd     = r_instr_id[11:8];
    assign w_rs1    = r_instr_id[7:4];
    assign w_rs2    = r_instr_id[3:0];

    assign w_stall = bus.load_execute
                  && (bus.rd_execute != '0)
                  && ((bus.rd_execute == w_rs1) || (bus.rd_execute == w_rs2))
                  && op_is_defined(w_opcode);

    // Flush outranks stall so a taken branch can squash a stalled instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_id <= '0;
        end else if (bus.flush) begin
            r_instr_id <= '0;
        end else if (!w_stall) begin
            r_instr_id <= bus.instr_fetch;
        end
    end

    assign w_ctrl             = decode_ctrl(w_opcode);
    assign bus.nop_mux_output = w_stall ? '0 : w_ctrl;
    assign bus.stall_fetch    = w_stall;
    assign bus.rs1_decode     = w_rs1;
    assign bus.rs2_decode     = w_rs2;
    assign bus.rd_decode      = w_rd;

    register_file u_register_file (
        .clk        (clk),
        .reset      (reset),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (bus.srcA),
        .o_rs2_data (bus.srcB),
        .i_we       (bus.wb_we),
        .i_wr_addr  (bus.wb_rd),
        .i_wr_data  (bus.wb_data)
    );
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import cpu_pkg::*;

    typedef struct {
        logic [15:0] ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        st;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if dif ();

    decode_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    exp_t  q  [$];
    string nq [$];
    int    total = 0;
    int    bad   = 0;
    exp_t  m_e;
    string m_n;

    // Inputs change 1 time unit after the rising edge; outputs are judged at the falling edge.
    task automatic set_in(input logic rst, input logic [15:0] ins, input logic fl, input logic le,
                          input logic [3:0] rde, input logic we, input logic [3:0] wrd,
                          input logic [15:0] wd);
        @(posedge clk);
        #1;
        reset            = rst;
        dif.instr_fetch  = ins;
        dif.flush        = fl;
        dif.load_execute = le;
        dif.rd_execute   = rde;
        dif.wb_we        = we;
        dif.wb_rd        = wrd;
        dif.wb_data      = wd;
    endtask

    task automatic push_exp(input string nm, input logic [15:0] ctrl, input logic [15:0] a,
                            input logic [15:0] b, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic [3:0] rd, input logic st);
        exp_t e;
        e.ctrl = ctrl; e.a = a; e.b = b; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.st = st;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            m_n = nq.pop_front();
            total++;
            if ({dif.nop_mux_output, dif.srcA, dif.srcB, dif.rs1_decode, dif.rs2_decode,
                 dif.rd_decode, dif.stall_fetch} !==
                {m_e.ctrl, m_e.a, m_e.b, m_e.rs1, m_e.rs2, m_e.rd, m_e.st}) begin
                bad++;
                $display("FAIL %s: got ctrl=%h a=%h b=%h rs1=%h rs2=%h rd=%h stall=%b | want ctrl=%h a=%h b=%h rs1=%h rs2=%h rd=%h stall=%b",
                         m_n, dif.nop_mux_output, dif.srcA, dif.srcB, dif.rs1_decode,
                         dif.rs2_decode, dif.rd_decode, dif.stall_fetch,
                         m_e.ctrl, m_e.a, m_e.b, m_e.rs1, m_e.rs2, m_e.rd, m_e.st);
            end
        end
    end

    initial begin
        logic [3:0]  r;
        logic [15:0] ins;
        reset            = 1'b1;
        dif.instr_fetch  = '0;
        dif.flush        = 1'b0;
        dif.load_execute = 1'b0;
        dif.rd_execute   = '0;
        dif.wb_we        = 1'b0;
        dif.wb_rd        = '0;
        dif.wb_data      = '0;

        // Reset state, with a non-zero fetch word that must be ignored.
        set_in(1, 16'h1234, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("reset", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
        set_in(0, 16'h1011, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("reset_hold", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);

        // Read R1..R15 after reset: ADD r0, ri, ri
        for (int i = 2; i <= 16; i++) begin
            r   = 4'(i);
            ins = (i <= 15) ? {4'h1, 4'h0, r, r} : 16'h0000;
            set_in(0, ins, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
            r   = 4'(i - 1);
            push_exp("read_after_reset", 16'h0080, 16'h0000, 16'h0000, r, r, 4'h0, 1'b0);
        end

        // Writeback R3, then read it
        set_in(0, 16'h1530, 0, 0, 4'h0, 1, 4'h3, 16'h1234);
        push_exp("wb_idle", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
        set_in(0, 16'h2634, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("wb_read_add", 16'h0080, 16'h1234, 16'h0000, 4'h3, 4'h0, 4'h5, 1'b0);

        // Bypass: R4 written while SUB r6, r3, r4 is decoded
        set_in(0, 16'h0000, 0, 0, 4'h0, 1, 4'h4, 16'hBEEF);
        push_exp("bypass_sub", 16'h0081, 16'h1234, 16'hBEEF, 4'h3, 4'h4, 4'h6, 1'b0);
        set_in(0, 16'h3440, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("bubble", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
        set_in(0, 16'h2120, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("r4_stored_and", 16'h0082, 16'hBEEF, 16'h0000, 4'h4, 4'h0, 4'h4, 1'b0);

        // Load-use on rs1=2: one stall cycle, instruction held, then issued
        set_in(0, 16'h4321, 0, 1, 4'h2, 0, 4'h0, 16'h0000);
        push_exp("loaduse_stall", 16'h0000, 16'h0000, 16'h0000, 4'h2, 4'h0, 4'h1, 1'b1);
        set_in(0, 16'h4321, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("loaduse_issue", 16'h0081, 16'h0000, 16'h0000, 4'h2, 4'h0, 4'h1, 1'b0);

        // Flush coinciding with a stall on rs2=1 of OR r3, r2, r1
        set_in(0, 16'h5555, 1, 1, 4'h1, 0, 4'h0, 16'h0000);
        push_exp("flush_stall", 16'h0000, 16'h0000, 16'h0000, 4'h2, 4'h1, 4'h3, 1'b1);
        set_in(0, 16'hC112, 0, 1, 4'h1, 0, 4'h0, 16'h0000);
        push_exp("after_flush", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);

        // Reserved opcode with matching load: no control, no stall; R0 write attempt
        set_in(0, 16'h0000, 0, 1, 4'h1, 1, 4'h0, 16'hFFFF);
        push_exp("reserved_no_stall", 16'h0000, 16'h0000, 16'h0000, 4'h1, 4'h2, 4'h1, 1'b0);
        set_in(0, 16'h8300, 0, 0, 4'h0, 1, 4'h0, 16'hFFFF);
        push_exp("bubble2", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
        set_in(0, 16'h9043, 0, 0, 4'h0, 1, 4'h0, 16'hFFFF);
        push_exp("r0_read_load", 16'h0190, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h3, 1'b0);
        set_in(0, 16'hA434, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("store", 16'h0040, 16'hBEEF, 16'h1234, 4'h4, 4'h3, 4'h0, 1'b0);
        set_in(0, 16'h6123, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("vadd", 16'h0227, 16'h1234, 16'hBEEF, 4'h3, 4'h4, 4'h4, 1'b0);

        // Reset arriving during a stall, with a pending writeback that must be dropped
        set_in(1, 16'h7530, 0, 1, 4'h3, 1, 4'h5, 16'hAAAA);
        push_exp("stall_pre_reset", 16'h0000, 16'h0000, 16'h1234, 4'h2, 4'h3, 4'h1, 1'b1);
        set_in(0, 16'h7530, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("reset_mid_stall", 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 1'b0);
        set_in(0, 16'h1055, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("srl_regs_cleared", 16'h0086, 16'h0000, 16'h0000, 4'h3, 4'h0, 4'h5, 1'b0);
        set_in(0, 16'h0000, 0, 0, 4'h0, 0, 4'h0, 16'h0000);
        push_exp("r5_not_written", 16'h0080, 16'h0000, 16'h0000, 4'h5, 4'h5, 4'h0, 1'b0);

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port instr_fetch  input  16  instruction word from fetch; fields opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0].
REQ-004 SHALL have port flush  input  1  discard the instruction held in decode (taken branch).
REQ-005 SHALL have port load_execute  input  1  instruction now in execute is a load.
REQ-006 SHALL have port rd_execute  input  4  destination register of the instruction now in execute.
REQ-007 SHALL have port wb_we  input  1  writeback write enable.
REQ-008 SHALL have port wb_rd  input  4  writeback destination register.
REQ-009 SHALL have port wb_data  input  16  writeback data.
REQ-010 SHALL have port nop_mux_output  output  16  control word to the decode/execute register; bits [15:10] always 0, [9] vector_wre, [8] load, [7] wre, [6] mem write enable, [5:4] writeback select, [3:0] aluOp.
REQ-011 SHALL have ports srcA, srcB  output  16 each  register-file read data for rs1 and rs2.
REQ-012 SHALL have ports rs1_decode, rs2_decode, rd_decode  output  4 each  register fields of the held instruction.
REQ-013 SHALL have port stall_fetch  output  1  PC and fetch must hold this cycle.

Function
REQ-014 SHALL hold one 16-bit IF/ID register instr_id; decode outputs are combinational from instr_id, giving latency 1 cycle from instr_fetch.
REQ-015 SHALL update instr_id at each rising edge with priority: reset -> 0x0000; else flush -> 0x0000; else stall -> hold; else instr_fetch.
REQ-016 SHALL decode the opcode into control word bits [9:0] as follows:
- 0x0 NOP: all zero.
- 0x1 ADD: wre=1, aluOp 0000.
- 0x2 SUB: wre=1, aluOp 0001.
- 0x3 AND: wre=1, aluOp 0010.
- 0x4 OR: wre=1, aluOp 0011.
- 0x5 XOR: wre=1, aluOp 0100.
- 0x6 SLL: wre=1, aluOp 0101.
- 0x7 SRL: wre=1, aluOp 0110.
- 0x8 LOAD: wre=1, load=1, wbsel 01, aluOp 0000.
- 0x9 STORE: memwe=1, aluOp 0000.
- 0xA VADD: vector_wre=1, wbsel 10, aluOp 0111.
- 0xB-0xF: all zero.
REQ-017 SHALL contain a 16x16 register file; R0 reads 0 always and writes to it are ignored.
REQ-018 SHALL write wb_data to wb_rd at the rising edge when wb_we=1 and wb_rd!=0.
REQ-019 SHALL bypass writeback to reads in the same cycle: if wb_we=1, wb_rd!=0 and wb_rd equals rs1 (or rs2), srcA (or srcB) SHALL equal wb_data.
REQ-020 SHALL assert stall (load-use hazard) when all of the following hold: load_execute=1, rd_execute!=0, rd_execute equals rs1 or rs2 of instr_id, and the instr_id opcode is not 0x0 or 0xB-0xF.
REQ-021 SHALL, while stall=1, drive nop_mux_output=0x0000 and stall_fetch=1; rs/rd fields and srcA/srcB continue to reflect instr_id.
REQ-022 SHALL make a load-use stall last exactly one cycle, because the inserted NOP clears load_execute on the next cycle.
REQ-023 SHALL give flush priority when flush and stall coincide: instr_id becomes 0x0000, and stall_fetch stays 1 for that cycle.
REQ-024 SHALL drive nop_mux_output=0x0000 when instr_id=0x0000 (bubble).

Reset
REQ-025 SHALL, on reset, clear instr_id and all 16 registers to 0; the outputs are then nop_mux_output=0, srcA=srcB=0, all rs/rd fields 0 and stall_fetch=0.
REQ-026 SHALL abort any pending stall when reset is asserted mid-stall; no write to the register file occurs during a reset cycle.

Structure
REQ-027 SHALL place the opcode constants, the control-word bit positions and the aluOp encodings in a shared package, cpu_pkg.
REQ-028 SHALL implement the register file as sub-module register_file (two read ports, one write port, R0 hardwired to zero, write bypass included).

Verification
REQ-029 SHALL cover reset: after reset, all outputs are 0 and reads of R1-R15 return 0.
REQ-030 SHALL cover writeback: wb_we=1, wb_rd=3, wb_data=0x1234, then instr 0x1530 (ADD rd5, rs1=3, rs2=0) -> srcA=0x1234, srcB=0, nop_mux_output=0x0080.
REQ-031 SHALL cover bypass: in the same cycle as the writeback of R4=0xBEEF, decode of an instr with rs2=4 -> srcB=0xBEEF.
REQ-032 SHALL cover load-use: load_execute=1, rd_execute=2, decode instr 0x2120 -> one cycle of nop_mux_output=0, stall_fetch=1, instr_id held; next cycle (load_execute=0) -> 0x0081 is issued.
REQ-033 SHALL cover flush with stall: flush=1 during a stall cycle -> instr_id=0 next cycle and nop_mux_output=0.
REQ-034 SHALL cover R0 and reserved opcodes: wb_rd=0 with wb_data=0xFFFF, then read R0 -> 0; opcode 0xC -> nop_mux_output=0 and no stall.
